// File: rtl/sat_pkg.sv
// Shared definitions for the SAT datapath: width helper and arbiter state encoding.
// Used by rr_onehot_arbiter (and the downstream one-hot encoder).
package sat_pkg;

  // Number of bits needed to hold indices 0 .. v-1 (minimum 1).
  function automatic int log2c(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/priority_onehot.sv
// Purely combinational lowest-index-wins one-hot picker.
// `none` flags an all-zero input, in which case `out` is also zero.
module priority_onehot #(
  parameter int N = 8
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic         none
);

  // Two's-complement isolates the lowest set bit in a single carry chain.
  assign out  = in & (~in + N'(1));
  assign none = ~|in;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Registered one-hot round-robin arbiter with valid/ready handshake.
// Define RR_ARB_ROTATE_EN for rotating priority; otherwise fixed priority, lowest index wins.
module rr_onehot_arbiter
  import sat_pkg::*;
#(
  parameter  int N  = 8,
  localparam int PW = log2c(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  input  logic          gnt_ready,
  output logic [PW-1:0] ptr
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [N-1:0] sel;
  logic         sel_none;
  logic [N-1:0] full_pick;

  priority_onehot #(.N(N)) u_full (
    .in   (req),
    .out  (full_pick),
    .none (sel_none)
  );

`ifdef RR_ARB_ROTATE_EN
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] k;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] search_p;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked_pick;
  logic          masked_none;

  // Index of the single set bit of the pending grant.
  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) k = PW'(i);
    end
  end

  // Explicit wrap keeps the pointer inside 0 .. N-1 for non power-of-2 N.
  assign next_ptr = (k == PW'(N - 1)) ? '0 : k + PW'(1);
  // On accept the new search already starts past the accepted grant.
  assign search_p = (state_q == ARB_HOLD) ? next_ptr : ptr_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(search_p));
    end
  end

  priority_onehot #(.N(N)) u_masked (
    .in   (req & mask),
    .out  (masked_pick),
    .none (masked_none)
  );

  assign sel = masked_none ? full_pick : masked_pick;
  assign ptr = ptr_q;
`else
  assign sel = full_pick;
  assign ptr = '0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
`ifdef RR_ARB_ROTATE_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (!sel_none) begin
          gnt_d   = sel;
          state_d = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (gnt_ready) begin
`ifdef RR_ARB_ROTATE_EN
          ptr_d   = next_ptr;
`endif
          gnt_d   = sel;
          state_d = sel_none ? ARB_IDLE : ARB_HOLD;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
`ifdef RR_ARB_ROTATE_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
`ifdef RR_ARB_ROTATE_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == ARB_HOLD);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter (N=8 and N=5 instances) against a behavioural model.
// Honours RR_ARB_ROTATE_EN the same way the design does.
module tb_rr_onehot_arbiter;

`ifdef RR_ARB_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, gnt_a;
  logic       vld_a, rdy_a;
  logic [2:0] ptr_a;
  logic [4:0] req_b, gnt_b;
  logic       vld_b, rdy_b;
  logic [2:0] ptr_b;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Model state per instance: [0] is N=8, [1] is N=5.
  int m_g [2];
  bit m_v [2];
  int m_p [2];

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a),
    .gnt_valid(vld_a), .gnt_ready(rdy_a), .ptr(ptr_a)
  );

  rr_onehot_arbiter #(.N(5)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b),
    .gnt_valid(vld_b), .gnt_ready(rdy_b), .ptr(ptr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First set bit of r scanning p, p+1, ..., wrapping modulo n.
  function automatic int sel_ref(input int r, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int j;
      j = (p + i) % n;
      if (r[j]) return 1 << j;
    end
    return 0;
  endfunction

  function automatic int idx_of(input int g, input int n);
    for (int i = 0; i < n; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input int n, input bit r, input int rq, input bit rd,
                            inout int g, inout bit v, inout int p);
    if (r) begin
      g = 0; v = 1'b0; p = 0;
    end else if (!v) begin
      if (rq != 0) begin
        g = sel_ref(rq, ROT ? p : 0, n);
        v = 1'b1;
      end
    end else if (rd) begin
      p = ROT ? (idx_of(g, n) + 1) % n : 0;
      g = sel_ref(rq, p, n);
      v = (g != 0);
    end
  endtask

  always @(posedge clk) begin
    model_step(8, rst, int'(req_a), rdy_a, m_g[0], m_v[0], m_p[0]);
    model_step(5, rst, int'(req_b), rdy_b, m_g[1], m_v[1], m_p[1]);
  end

  // Compare process: DUT vs model on every falling edge once reset has been applied.
  initial begin
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      check("a_gnt", gnt_a, m_g[0]);
      check("a_valid", vld_a, int'(m_v[0]));
      check("a_ptr", ptr_a, m_p[0]);
      check("a_onehot", $countones(gnt_a) <= 1, 1);
      check("b_gnt", gnt_b, m_g[1]);
      check("b_valid", vld_b, int'(m_v[1]));
      check("b_ptr", ptr_b, m_p[1]);
      check("b_onehot", $countones(gnt_b) <= 1, 1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_a = 8'hFF; rdy_a = 1'b0; req_b = '0; rdy_b = 1'b0;

    // Reset with all requests asserted.
    tick(); tick();
    check("rst_gnt", gnt_a, 0);
    check("rst_valid", vld_a, 0);
    check("rst_ptr", ptr_a, 0);
    rst = 1'b0;
    tick();
    check("rel_gnt", gnt_a, 8'h01);
    check("rel_valid", vld_a, 1);

    // Hold: grant frozen while not accepted, even with req dropped.
    rst = 1'b1; tick();
    rst = 1'b0; req_a = 8'b0010_0100; tick();
    check("hold_first", gnt_a, 8'h04);
    req_a = 8'h00;
    repeat (3) begin
      tick();
      check("hold_gnt", gnt_a, 8'h04);
      check("hold_valid", vld_a, 1);
    end

    // Back-to-back accepts.
    req_a = 8'b0010_0100; rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ROT) begin
        check("b2b_gnt", gnt_a, (i % 2 == 0) ? 8'h20 : 8'h04);
        check("b2b_ptr", ptr_a, (i % 2 == 0) ? 3 : 6);
      end else begin
        check("b2b_gnt", gnt_a, 8'h04);
        check("b2b_ptr", ptr_a, 0);
      end
    end

    // Reset mid-HOLD drops the grant without counting the accept.
    rst = 1'b1; rdy_a = 1'b0; req_a = 8'h40; tick();
    rst = 1'b0; tick();
    check("mid_pend", gnt_a, 8'h40);
    rst = 1'b1; rdy_a = 1'b1; tick();
    check("mid_gnt", gnt_a, 0);
    check("mid_valid", vld_a, 0);
    check("mid_ptr", ptr_a, 0);
    rst = 1'b0; req_a = 8'h00; tick();
    check("mid_after_ptr", ptr_a, 0);
    check("mid_after_valid", vld_a, 0);

    // Two requesters, continuous accept.
    req_a = 8'b1000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ROT) begin
        check("pair_gnt", gnt_a, (i == 1) ? 8'h80 : 8'h02);
        check("pair_ptr", ptr_a, (i == 1) ? 2 : 0);
      end else begin
        check("pair_gnt", gnt_a, 8'h02);
        check("pair_ptr", ptr_a, 0);
      end
    end
    rdy_a = 1'b0; req_a = 8'h00;

    // Wrap on N=5.
    rst = 1'b1; tick();
    rst = 1'b0; req_b = 5'b00001; rdy_b = 1'b0; tick();
    check("wrap_first", gnt_b, 5'b00001);
    req_b = 5'b10001; rdy_b = 1'b1; tick();
    check("wrap_gnt1", gnt_b, ROT ? 5'b10000 : 5'b00001);
    check("wrap_ptr1", ptr_b, ROT ? 1 : 0);
    tick();
    check("wrap_gnt2", gnt_b, 5'b00001);
    check("wrap_ptr2", ptr_b, 0);

    // Randomized traffic on both instances, checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      req_a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req_b = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      rdy_a = ($urandom_range(0, 2) != 0);
      rdy_b = ($urandom_range(0, 2) != 0);
      tick();
    end

    done = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
# rr_onehot_arbiter

Round-robin arbiter that reduces an N-bit request vector (unassigned variables, unsatisfied clauses, or similar) to a registered, strictly one-hot grant with a valid/ready handshake. It sits directly upstream of the one-hot `encoder`. The `encoder` requires at most one active input bit, so this block guarantees that property on every cycle. Fairness comes from a rotating priority pointer that advances past each accepted grant.

## Interface
- `N`, default 8: request/grant width; N ≥ 2, need not be a power of 2.
- `PW`, default log2c(N): pointer width (derived localparam, not overridable).

- `clk`  in  1: the single clock for the block.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  N: request vector, level-sensitive, sampled every cycle; need not be held.
- `gnt`  out  N: registered grant; all-zero or exactly one bit set.
- `gnt_valid`  out  1: `gnt` holds a pending grant.
- `gnt_ready`  in  1: consumer accepts `gnt` when `gnt_valid & gnt_ready`.
- `ptr`  out  PW: current highest-priority index (debug/visibility).

## Operation
- Two states, encoded in `gnt_valid`: IDLE (0) and HOLD (1).
- Search function: `sel(r, p)` returns a one-hot vector of the first set bit of `r`, scanning indices p, p+1, …, N-1, 0, …, p-1. Returns zero if `r` is zero.
- Search method: mask off bits below `p`. If the masked vector is non-zero, fixed-priority pick from it; otherwise fixed-priority pick from unmasked `r`.
- In IDLE, if `|req`:
  - `gnt <= sel(req, ptr)` and `gnt_valid <= 1` (go to HOLD).
  - Otherwise remain in IDLE with `gnt = 0`.
- In HOLD without accept: `gnt` and `gnt_valid` are frozen, even if `req` drops or changes.
- In HOLD with accept (`gnt_ready` high), with k = index of `gnt`:
  - `ptr <= (k == N-1) ? 0 : k+1`. The wrap is explicit, so the pointer never takes values ≥ N.
  - Back-to-back issue: `gnt <= sel(req, k+1 wrapped)`. The accepted bit is not masked from `req`.
  - If the result is zero, `gnt <= 0` and `gnt_valid <= 0` (return to IDLE).
- `ptr` changes only on accept.
- `gnt_ready` is ignored in IDLE.
- Invariant: `gnt_valid == |gnt`, and `gnt` is never multi-hot.

## Timing
- Reset values: `gnt = 0`, `gnt_valid = 0`, `ptr = 0`. Reset wins over every other event in the same cycle.
- Latency: `req` rising in IDLE produces `gnt_valid` 1 cycle later.
- Throughput: one grant per cycle while `req` stays non-zero and `gnt_ready` stays high.
- Reset mid-HOLD: the grant is dropped without an accept, and the consumer sees `gnt_valid` low the next cycle.
- `gnt` is driven directly from flops; there is no combinational path from `req` to `gnt`.
- Accepting a grant while `req` becomes zero in the same cycle returns to IDLE with no bubble penalty.

## Configuration
- `RR_ARB_ROTATE_EN` defined: round-robin behaviour as described above.
- `RR_ARB_ROTATE_EN` undefined: fixed priority with the lowest index winning.
  - `ptr` is tied to 0, and its flops and update logic are removed.
  - `sel(r, 0)` is used everywhere.
  - Handshake and timing are unchanged.

## Structure
- Shared package `sat_pkg`:
  - `log2c` function (single definition shared with `encoder`).
  - State encoding constants `ARB_IDLE` / `ARB_HOLD`.
- Sub-module `priority_onehot #(N)`: purely combinational lowest-index one-hot picker (`in` → `out`, `none`). It is instantiated twice, for the masked and unmasked paths.
- The wrap-aware pointer increment and the mask generation are local to `rr_onehot_arbiter`.

## Test plan
All scenarios use N=8 unless stated otherwise.
1. Reset:
   - `rst=1` with `req=8'hFF` for 2 cycles → `gnt=0`, `gnt_valid=0`, `ptr=0`.
   - Release reset → `gnt=8'h01` one cycle later.
2. Hold:
   - `req=8'b0010_0100`, `gnt_ready=0` → `gnt=8'b0000_0100` from cycle 1.
   - Then set `req=0` for 3 cycles → `gnt` stays `8'b0000_0100` with `gnt_valid=1`.
3. Back-to-back:
   - `req=8'b0010_0100`, `gnt_ready=1` continuously → grants `04`, `20`, `04`, `20`… on consecutive cycles.
   - `ptr` sequence: 0, 3, 6, 3, 6…
4. Wrap, N=5:
   - `req=5'b10001` with `ptr=1` → `gnt=5'b10000`.
   - Accept → `ptr=0`, next `gnt=5'b00001`.
5. Reset mid-HOLD:
   - With `gnt=8'h40` pending, `rst=1` alongside `gnt_ready=1` → next cycle `gnt=0`, `gnt_valid=0`, `ptr=0`.
   - The accept is not counted.
6. Macro off (`RR_ARB_ROTATE_EN` undefined):
   - `req=8'b1000_0010`, `gnt_ready=1` → `gnt=8'b0000_0010` every cycle.
   - `ptr` stays 0.
